mem_bus_arbiter: RTL and testbench

- Arbitrates one shared memory port (qspi_innermem read/write channel) between three masters: CPU instruction fetch (I), CPU data load/store (D) and UART monitor DMA (U).
- Exactly one transaction is outstanding at a time.
- Routes the completion strobe (read_valid / write_finish) back to the owning master only.
- Replaces the combinational request OR-ing in bus_gather with a registered, ownership-tracked sequencer.

---
 rtl/mem_bus_arb_pkg.sv | 25 ++
 rtl/mem_bus_arb_pick.sv | 51 +++++
 rtl/mem_bus_arbiter.sv | 210 +++++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_arb_pkg.sv
// Shared owner codes, sequencer states and direction codes for mem_bus_arbiter.
// Round-robin arbitration is selected with MEM_BUS_ARB_RR_EN.
package mem_bus_arb_pkg;

    localparam logic [1:0] OWN_I    = 2'd0;
    localparam logic [1:0] OWN_D    = 2'd1;
    localparam logic [1:0] OWN_U    = 2'd2;
    localparam logic [1:0] OWN_NONE = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;

    typedef enum logic {
        DIR_RD = 1'b0,
        DIR_WR = 1'b1
    } dir_e;

    function automatic logic [1:0] next_master(input logic [1:0] m);
        return (m == OWN_U) ? OWN_I : m + 2'd1;
    endfunction

endpackage

// File: rtl/mem_bus_arb_pick.sv
// Winner/direction select for the three masters; fixed priority U > D > I by default,
// round-robin with a registered pointer when MEM_BUS_ARB_RR_EN is defined.
module mem_bus_arb_pick
    import mem_bus_arb_pkg::*;
(
`ifdef MEM_BUS_ARB_RR_EN
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       grant_i,
`endif
    input  logic [2:0] rd_req_i,
    input  logic [2:0] wr_req_i,
    output logic       valid_o,
    output logic [1:0] owner_o,
    output dir_e       dir_o
);

`ifdef MEM_BUS_ARB_RR_EN
    logic [1:0] ptr_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q <= OWN_U;
        end else if (grant_i) begin
            ptr_q <= next_master(owner_o);
        end
    end
`endif

    // Walk candidates from lowest to highest priority so the last hit wins.
    always_comb begin
        logic [1:0] m;
        m       = OWN_NONE;
        valid_o = 1'b0;
        owner_o = OWN_NONE;
        dir_o   = DIR_RD;
        for (int j = 2; j >= 0; j--) begin
`ifdef MEM_BUS_ARB_RR_EN
            m = 2'((int'(ptr_q) + j) % 3);
`else
            m = 2'(2 - j);
`endif
            if (rd_req_i[m] || wr_req_i[m]) begin
                valid_o = 1'b1;
                owner_o = m;
                dir_o   = wr_req_i[m] ? DIR_WR : DIR_RD;
            end
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Registered single-outstanding sequencer sharing one memory port between I, D and U masters.
// Define MEM_BUS_ARB_RR_EN for round-robin arbitration instead of fixed priority.
module mem_bus_arbiter
    import mem_bus_arb_pkg::*;
#(
    parameter int ADR_W  = 32,
    parameter int DAT_W  = 32,
    parameter int TO_CYC = 4096
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_read_req,
    input  logic             i_read_w,
    input  logic             i_read_hw,
    input  logic [ADR_W-1:0] i_read_adr,
    output logic             i_read_valid,
    input  logic             d_read_req,
    input  logic             d_write_req,
    input  logic             d_read_w,
    input  logic             d_read_hw,
    input  logic             d_write_w,
    input  logic             d_write_hw,
    input  logic [ADR_W-1:0] d_read_adr,
    input  logic [ADR_W-1:0] d_write_adr,
    input  logic [DAT_W-1:0] d_write_data,
    output logic             d_read_valid,
    output logic             d_write_finish,
    input  logic             u_read_req,
    input  logic             u_write_req,
    input  logic             u_read_w,
    input  logic             u_write_w,
    input  logic [ADR_W-1:0] u_read_adr,
    input  logic [ADR_W-1:0] u_write_adr,
    input  logic [DAT_W-1:0] u_write_data,
    output logic             u_read_valid,
    output logic             u_write_finish,
    output logic             read_req,
    output logic             write_req,
    output logic             read_w,
    output logic             read_hw,
    output logic             write_w,
    output logic             write_hw,
    output logic [ADR_W-1:0] read_adr,
    output logic [ADR_W-1:0] write_adr,
    output logic [DAT_W-1:0] write_data,
    input  logic             read_valid,
    input  logic             write_finish,
    output logic             busy,
    output logic [1:0]       owner,
    output logic             err_timeout
);

    localparam int CNT_W = $clog2(TO_CYC + 1);

    state_e             state_q, state_d;
    logic [1:0]         owner_q, owner_d;
    dir_e               dir_q, dir_d;
    logic [ADR_W-1:0]   adr_q, adr_d;
    logic [DAT_W-1:0]   data_q, data_d;
    logic               w_q, w_d, hw_q, hw_d;
    logic               rreq_q, rreq_d, wreq_q, wreq_d;
    logic [CNT_W-1:0]   wd_q, wd_d;
    logic               err_q, err_d;

    logic               pick_valid;
    logic [1:0]         pick_owner;
    dir_e               pick_dir;
    logic               done_w, timeout_w, fire_w;

`ifdef MEM_BUS_ARB_RR_EN
    logic               grant;
    assign grant = (state_q == ST_IDLE) && pick_valid;
`endif

    mem_bus_arb_pick u_pick (
`ifdef MEM_BUS_ARB_RR_EN
        .clk_i    (clk),
        .rst_i    (rst),
        .grant_i  (grant),
`endif
        .rd_req_i ({u_read_req, d_read_req, i_read_req}),
        .wr_req_i ({u_write_req, d_write_req, 1'b0}),
        .valid_o  (pick_valid),
        .owner_o  (pick_owner),
        .dir_o    (pick_dir)
    );

    assign done_w    = (dir_q == DIR_RD) ? read_valid : write_finish;
    assign timeout_w = (wd_q == CNT_W'(TO_CYC));
    assign fire_w    = (state_q == ST_WAIT) && (done_w || timeout_w);

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        dir_d   = dir_q;
        adr_d   = adr_q;
        data_d  = data_q;
        w_d     = w_q;
        hw_d    = hw_q;
        rreq_d  = 1'b0;
        wreq_d  = 1'b0;
        wd_d    = wd_q;
        err_d   = err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    owner_d = pick_owner;
                    dir_d   = pick_dir;
                    state_d = ST_ISSUE;
                    data_d  = '0;
                    hw_d    = 1'b0;
                    case (pick_owner)
                        OWN_I: begin
                            adr_d = i_read_adr;
                            w_d   = i_read_w;
                            hw_d  = i_read_hw;
                        end
                        OWN_D: begin
                            if (pick_dir == DIR_WR) begin
                                adr_d  = d_write_adr;
                                data_d = d_write_data;
                                w_d    = d_write_w;
                                hw_d   = d_write_hw;
                            end else begin
                                adr_d = d_read_adr;
                                w_d   = d_read_w;
                                hw_d  = d_read_hw;
                            end
                        end
                        default: begin
                            if (pick_dir == DIR_WR) begin
                                adr_d  = u_write_adr;
                                data_d = u_write_data;
                                w_d    = u_write_w;
                            end else begin
                                adr_d = u_read_adr;
                                w_d   = u_read_w;
                            end
                        end
                    endcase
                end
            end
            ST_ISSUE: begin
                rreq_d  = (dir_q == DIR_RD);
                wreq_d  = (dir_q == DIR_WR);
                wd_d    = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (fire_w) begin
                    state_d = ST_IDLE;
                    owner_d = OWN_NONE;
                    if (!done_w) err_d = 1'b1;
                end else begin
                    wd_d = wd_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            owner_q <= OWN_NONE;
            dir_q   <= DIR_RD;
            adr_q   <= '0;
            data_q  <= '0;
            w_q     <= 1'b0;
            hw_q    <= 1'b0;
            rreq_q  <= 1'b0;
            wreq_q  <= 1'b0;
            wd_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            dir_q   <= dir_d;
            adr_q   <= adr_d;
            data_q  <= data_d;
            w_q     <= w_d;
            hw_q    <= hw_d;
            rreq_q  <= rreq_d;
            wreq_q  <= wreq_d;
            wd_q    <= wd_d;
            err_q   <= err_d;
        end
    end

    // Completion strobes are combinational so read data lines up with the owner's strobe.
    assign i_read_valid   = fire_w && (owner_q == OWN_I) && (dir_q == DIR_RD);
    assign d_read_valid   = fire_w && (owner_q == OWN_D) && (dir_q == DIR_RD);
    assign d_write_finish = fire_w && (owner_q == OWN_D) && (dir_q == DIR_WR);
    assign u_read_valid   = fire_w && (owner_q == OWN_U) && (dir_q == DIR_RD);
    assign u_write_finish = fire_w && (owner_q == OWN_U) && (dir_q == DIR_WR);

    assign read_req    = rreq_q;
    assign write_req   = wreq_q;
    assign read_w      = w_q;
    assign read_hw     = hw_q;
    assign write_w     = w_q;
    assign write_hw    = hw_q;
    assign read_adr    = adr_q;
    assign write_adr   = adr_q;
    assign write_data  = data_q;
    assign busy        = (state_q != ST_IDLE);
    assign owner       = owner_q;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios plus randomized request sets
// checked against a transaction-level arbitration model.
module tb_mem_bus_arbiter;

    localparam int TO = 16;
    // channel index: 0 I rd, 1 D rd, 2 D wr, 3 U rd, 4 U wr
    localparam int MST [5] = '{0, 1, 1, 2, 2};

    logic        clk = 1'b0;
    logic        rst;
    logic        i_read_req, i_read_w, i_read_hw, i_read_valid;
    logic [31:0] i_read_adr;
    logic        d_read_req, d_write_req, d_read_w, d_read_hw, d_write_w, d_write_hw;
    logic [31:0] d_read_adr, d_write_adr, d_write_data;
    logic        d_read_valid, d_write_finish;
    logic        u_read_req, u_write_req, u_read_w, u_write_w;
    logic [31:0] u_read_adr, u_write_adr, u_write_data;
    logic        u_read_valid, u_write_finish;
    logic        read_req, write_req, read_w, read_hw, write_w, write_hw;
    logic [31:0] read_adr, write_adr, write_data;
    logic        read_valid, write_finish, busy, err_timeout;
    logic [1:0]  owner;

    int          errors = 0;
    int          checks = 0;
    bit          pend [5];
    logic [31:0] ch_adr [5];
    logic [31:0] ch_dat [5];
    logic        ch_w [5];
    logic        ch_hw [5];
    int          rr_ptr = 2;
    bit          keep = 0;

    mem_bus_arbiter #(.ADR_W(32), .DAT_W(32), .TO_CYC(TO)) dut (
        .clk(clk), .rst(rst),
        .i_read_req(i_read_req), .i_read_w(i_read_w), .i_read_hw(i_read_hw),
        .i_read_adr(i_read_adr), .i_read_valid(i_read_valid),
        .d_read_req(d_read_req), .d_write_req(d_write_req),
        .d_read_w(d_read_w), .d_read_hw(d_read_hw), .d_write_w(d_write_w), .d_write_hw(d_write_hw),
        .d_read_adr(d_read_adr), .d_write_adr(d_write_adr), .d_write_data(d_write_data),
        .d_read_valid(d_read_valid), .d_write_finish(d_write_finish),
        .u_read_req(u_read_req), .u_write_req(u_write_req),
        .u_read_w(u_read_w), .u_write_w(u_write_w),
        .u_read_adr(u_read_adr), .u_write_adr(u_write_adr), .u_write_data(u_write_data),
        .u_read_valid(u_read_valid), .u_write_finish(u_write_finish),
        .read_req(read_req), .write_req(write_req),
        .read_w(read_w), .read_hw(read_hw), .write_w(write_w), .write_hw(write_hw),
        .read_adr(read_adr), .write_adr(write_adr), .write_data(write_data),
        .read_valid(read_valid), .write_finish(write_finish),
        .busy(busy), .owner(owner), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "bench time limit expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] strobes();
        return {u_write_finish, u_read_valid, d_write_finish, d_read_valid, i_read_valid};
    endfunction

    task automatic drive();
        i_read_req   = pend[0]; i_read_adr  = ch_adr[0]; i_read_w  = ch_w[0]; i_read_hw  = ch_hw[0];
        d_read_req   = pend[1]; d_read_adr  = ch_adr[1]; d_read_w  = ch_w[1]; d_read_hw  = ch_hw[1];
        d_write_req  = pend[2]; d_write_adr = ch_adr[2]; d_write_w = ch_w[2]; d_write_hw = ch_hw[2];
        d_write_data = ch_dat[2];
        u_read_req   = pend[3]; u_read_adr  = ch_adr[3]; u_read_w  = ch_w[3];
        u_write_req  = pend[4]; u_write_adr = ch_adr[4]; u_write_w = ch_w[4];
        u_write_data = ch_dat[4];
    endtask

    // Reference arbitration: masters ordered by priority, write before read within a master.
    function automatic int pick();
        int order [3];
        int m;
`ifdef MEM_BUS_ARB_RR_EN
        order = '{rr_ptr, (rr_ptr + 1) % 3, (rr_ptr + 2) % 3};
`else
        order = '{2, 1, 0};
`endif
        for (int j = 0; j < 3; j++) begin
            m = order[j];
            if (m == 2 && pend[4]) return 4;
            if (m == 2 && pend[3]) return 3;
            if (m == 1 && pend[2]) return 2;
            if (m == 1 && pend[1]) return 1;
            if (m == 0 && pend[0]) return 0;
        end
        return -1;
    endfunction

    task automatic wait_req(output bit got, output int waited);
        got = 0;
        waited = 0;
        for (int k = 0; k < 12; k++) begin
            cyc();
            waited = k + 1;
            if (read_req || write_req) begin
                got = 1;
                break;
            end
        end
        chk("req_seen", 64'(got), 64'd1);
    endtask

    task automatic run_txn(input int ch, input int lat, input bit spur, output int waited);
        bit got;
        bit wr;
        wr = (ch == 2 || ch == 4);
        rr_ptr = (MST[ch] + 1) % 3;
        wait_req(got, waited);
        if (!got) return;
        chk("req_dir", {read_req, write_req}, wr ? 2'b01 : 2'b10);
        chk("owner", owner, MST[ch]);
        chk("busy_req", busy, 1);
        if (wr) begin
            chk("write_adr", write_adr, ch_adr[ch]);
            chk("write_data", write_data, ch_dat[ch]);
            chk("write_size", {write_w, write_hw}, {ch_w[ch], (ch == 4) ? 1'b0 : ch_hw[ch]});
        end else begin
            chk("read_adr", read_adr, ch_adr[ch]);
            chk("read_size", {read_w, read_hw}, {ch_w[ch], (ch == 3) ? 1'b0 : ch_hw[ch]});
        end
        for (int j = 1; j < lat; j++) begin
            cyc();
            if (spur && j == 1) begin
                if (wr) read_valid = 1'b1;
                else    write_finish = 1'b1;
            end
            #1;
            chk("no_early_strobe", strobes(), 0);
            chk("req_single_pulse", {read_req, write_req}, 0);
            chk("busy_wait", busy, 1);
            chk("owner_wait", owner, MST[ch]);
            read_valid = 1'b0;
            write_finish = 1'b0;
        end
        cyc();
        if (wr) write_finish = 1'b1;
        else    read_valid = 1'b1;
        #1;
        chk("strobe", strobes(), 64'(5'b00001 << ch));
        cyc();
        read_valid = 1'b0;
        write_finish = 1'b0;
        if (!keep) begin
            pend[ch] = 0;
            drive();
        end
        #1;
        chk("idle_busy", busy, 0);
        chk("idle_owner", owner, 3);
    endtask

    function automatic bit any_pend();
        return pend[0] | pend[1] | pend[2] | pend[3] | pend[4];
    endfunction

    task automatic serve();
        int guard;
        int ch;
        int w;
        guard = 0;
        drive();
        while (any_pend() && guard < 20) begin
            ch = pick();
            run_txn(ch, $urandom_range(2, 5), $urandom_range(0, 1) == 1, w);
            guard++;
        end
    endtask

    initial begin
        bit got;
        int w;
        int n;
        for (int c = 0; c < 5; c++) begin
            pend[c] = 0; ch_adr[c] = '0; ch_dat[c] = '0; ch_w[c] = 1'b0; ch_hw[c] = 1'b0;
        end
        drive();
        read_valid = 1'b0;
        write_finish = 1'b0;
        rst = 1'b1;
        cyc();
        cyc();
        chk("rst_busy", busy, 0);
        chk("rst_owner", owner, 3);
        chk("rst_reqs", {read_req, write_req}, 0);
        chk("rst_err", err_timeout, 0);
        chk("rst_adr", read_adr, 0);
        chk("rst_data", write_data, 0);
        chk("rst_strobes", strobes(), 0);
        rst = 1'b0;
        cyc();

        // single I fetch, memory answers 3 cycles after the request pulse
        pend[0] = 1; ch_adr[0] = 32'h100; ch_w[0] = 1'b1;
        drive();
        run_txn(0, 3, 0, w);
        chk("issue_latency", w, 2);

        // simultaneous I read, D write, U read
        pend[0] = 1; pend[2] = 1; pend[3] = 1;
        ch_adr[2] = 32'h200; ch_dat[2] = 32'hDEADBEEF; ch_w[2] = 1'b1;
        ch_adr[3] = 32'h300;
        serve();

        // spurious completions in IDLE
        read_valid = 1'b1;
        #1;
        chk("spur_idle_rd", strobes(), 0);
        cyc();
        read_valid = 1'b0;
        write_finish = 1'b1;
        #1;
        chk("spur_idle_wr", strobes(), 0);
        cyc();
        write_finish = 1'b0;
        #1;
        chk("spur_idle_busy", busy, 0);
        chk("spur_idle_owner", owner, 3);

        // wrong-direction completion while a D read is outstanding
        pend[1] = 1; ch_adr[1] = 32'h444;
        drive();
        run_txn(1, 4, 1, w);

`ifdef MEM_BUS_ARB_RR_EN
        pend[0] = 1; pend[1] = 1; pend[3] = 1;
        keep = 1;
        drive();
        for (int g = 0; g < 6; g++) begin
            n = pick();
            run_txn(n, 2, 0, w);
        end
        keep = 0;
        serve();
`endif

        // randomized request sets
        for (int r = 0; r < 20; r++) begin
            for (int c = 0; c < 5; c++) begin
                pend[c]   = $urandom_range(0, 1) == 1;
                ch_adr[c] = $urandom;
                ch_dat[c] = $urandom;
                ch_w[c]   = $urandom_range(0, 1) == 1;
                ch_hw[c]  = (c >= 3) ? 1'b0 : ($urandom_range(0, 1) == 1);
            end
            serve();
        end

        // watchdog: no memory response
        pend[0] = 1; ch_adr[0] = 32'h5A0;
        drive();
        chk("err_before_to", err_timeout, 0);
        wait_req(got, w);
        n = 0;
        for (int k = 1; k <= 3 * TO; k++) begin
            cyc();
            #1;
            if (strobes() != 0) begin
                n = k;
                break;
            end
        end
        chk("timeout_cycles", n, TO);
        chk("timeout_strobe", strobes(), 5'b00001);
        cyc();
        pend[0] = 0;
        drive();
        #1;
        chk("timeout_err", err_timeout, 1);
        chk("timeout_busy", busy, 0);
        rr_ptr = 1;
        pend[1] = 1; ch_adr[1] = 32'h600;
        serve();
        chk("err_sticky", err_timeout, 1);

        // reset during WAIT of a D read
        pend[1] = 1; ch_adr[1] = 32'h700;
        drive();
        wait_req(got, w);
        cyc();
        rst = 1'b1;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_owner", owner, 3);
        chk("midrst_err", err_timeout, 0);
        chk("midrst_adr", read_adr, 0);
        read_valid = 1'b1;
        #1;
        chk("midrst_strobes", strobes(), 0);
        cyc();
        read_valid = 1'b0;
        rst = 1'b0;
        rr_ptr = 2;
        serve();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
